// File: rtl/lut_sweep_eval.sv
// Loadable 2^N-entry truth table with single-vector evaluation,
// an exhaustive valid/ready sweep and a minterm count.
module lut_sweep_eval #(
   parameter int N = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               tt_load,
   input  logic [(1<<N)-1:0]  tt_in,
   input  logic               eval_en,
   input  logic [N-1:0]       x,
   output logic               eval_f,
   output logic               eval_valid,
   input  logic               start,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [N-1:0]       out_idx,
   output logic               out_f,
   output logic               busy,
   output logic               done,
   output logic [N:0]         ones_count
);

   localparam int DEPTH = 1 << N;
   localparam logic [N-1:0] LAST = '1;

   typedef enum logic [1:0] {
      IDLE,
      SWEEP,
      DONE
   } state_t;

   state_t state, state_nx;
   logic [DEPTH-1:0] table_q;
   logic xfer;
   logic last;

   assign out_f = table_q[out_idx];
   assign xfer  = (state == SWEEP) && out_valid && out_ready;
   assign last  = (out_idx == LAST);
   assign busy  = (state == SWEEP);
   assign done  = (state == DONE);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (start) state_nx = SWEEP;
         SWEEP:   if (xfer && last) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Eval reads table_q before a same-cycle load lands.
   always_ff @(posedge clk) begin
      if (rst) begin
         table_q    <= '0;
         eval_f     <= 1'b0;
         eval_valid <= 1'b0;
         out_idx    <= '0;
         out_valid  <= 1'b0;
         ones_count <= '0;
      end else begin
         eval_valid <= 1'b0;
         if (state == IDLE) begin
            if (tt_load) table_q <= tt_in;
            if (start) begin
               out_idx    <= '0;
               ones_count <= '0;
               out_valid  <= 1'b1;
            end else if (eval_en) begin
               eval_f     <= table_q[x];
               eval_valid <= 1'b1;
            end
         end
         if (xfer) begin
            ones_count <= ones_count + {{N{1'b0}}, out_f};
            if (last) out_valid <= 1'b0;
            else      out_idx   <= out_idx + N'(1);
         end
      end
   end

endmodule

// File: tb/tb_lut_sweep_eval.sv
// Directed bench for lut_sweep_eval with N=4.
// Tasks exercise eval, sweeps, stalls, reset abort and load ordering.
module tb_lut_sweep_eval;

   localparam int N = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          tt_load;
   logic [15:0]   tt_in;
   logic          eval_en;
   logic [N-1:0]  x;
   logic          eval_f;
   logic          eval_valid;
   logic          start;
   logic          out_valid;
   logic          out_ready;
   logic [N-1:0]  out_idx;
   logic          out_f;
   logic          busy;
   logic          done;
   logic [N:0]    ones_count;

   int n_checks = 0;
   int n_pass = 0;

   logic [15:0] ref_tt;

   lut_sweep_eval #(.N(N)) dut (
      .clk        (clk),
      .rst        (rst),
      .tt_load    (tt_load),
      .tt_in      (tt_in),
      .eval_en    (eval_en),
      .x          (x),
      .eval_f     (eval_f),
      .eval_valid (eval_valid),
      .start      (start),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_idx    (out_idx),
      .out_f      (out_f),
      .busy       (busy),
      .done       (done),
      .ones_count (ones_count)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; tt_load = 0; tt_in = '0; eval_en = 0; x = '0;
      start = 0; out_ready = 0;
      step();
      step();
      rst = 1'b0;
      n_checks++;
      if ({eval_f, eval_valid, out_valid, busy, done} !== 5'b0)
         $display("FAIL reset_flags got=%b want=00000",
                  {eval_f, eval_valid, out_valid, busy, done});
      else n_pass++;
      n_checks++;
      if (ones_count !== 5'd0)
         $display("FAIL reset_ones got=%0d want=0", ones_count);
      else n_pass++;
      n_checks++;
      if ({out_idx, out_f} !== 5'd0)
         $display("FAIL reset_idx got=%0d/%b want=0/0", out_idx, out_f);
      else n_pass++;
   endtask

   task automatic test_eval();
      ref_tt = 16'hF830;
      tt_load = 1; tt_in = ref_tt;
      step();
      tt_load = 0;
      eval_en = 1; x = 4'b1011;
      step();
      eval_en = 0;
      n_checks++;
      if ({eval_f, eval_valid} !== 2'b11)
         $display("FAIL eval_1011 got=%b%b want=11", eval_f, eval_valid);
      else n_pass++;
      step();
      n_checks++;
      if ({eval_f, eval_valid} !== 2'b10)
         $display("FAIL eval_hold got=%b%b want=10", eval_f, eval_valid);
      else n_pass++;
      eval_en = 1; x = 4'b0110;
      step();
      eval_en = 0;
      n_checks++;
      if ({eval_f, eval_valid} !== 2'b01)
         $display("FAIL eval_0110 got=%b%b want=01", eval_f, eval_valid);
      else n_pass++;
      step();
   endtask

   task automatic test_sweep_full();
      int errs;
      out_ready = 1;
      start = 1; eval_en = 1; x = 4'b1011;
      step();
      start = 0; eval_en = 0;
      n_checks++;
      if ({busy, out_valid, eval_valid} !== 3'b110)
         $display("FAIL start_wins got=%b want=110",
                  {busy, out_valid, eval_valid});
      else n_pass++;
      errs = 0;
      for (int i = 0; i < 16; i++) begin
         if (i == 3) begin start = 1; eval_en = 1; end
         else begin start = 0; eval_en = 0; end
         if (!out_valid || out_idx !== 4'(i) || out_f !== ref_tt[i]
             || !busy || done || eval_valid) begin
            errs++;
            $display("FAIL sweep_vec i=%0d got idx=%0d f=%b v=%b want f=%b",
                     i, out_idx, out_f, out_valid, ref_tt[i]);
         end
         step();
      end
      start = 0; eval_en = 0;
      n_checks++;
      if (errs != 0)
         $display("FAIL sweep_stream got=%0d bad want=0", errs);
      else n_pass++;
      n_checks++;
      if ({done, out_valid, busy, out_idx} !== {3'b100, 4'd15})
         $display("FAIL sweep_done got=%b%b%b idx=%0d want=100 idx=15",
                  done, out_valid, busy, out_idx);
      else n_pass++;
      n_checks++;
      if (ones_count !== 5'd7)
         $display("FAIL sweep_ones got=%0d want=7", ones_count);
      else n_pass++;
      step();
      n_checks++;
      if ({done, busy, ones_count} !== {2'b00, 5'd7})
         $display("FAIL sweep_idle got=%b%b %0d want=00 7",
                  done, busy, ones_count);
      else n_pass++;
   endtask

   task automatic test_stall();
      int k;
      int exp_idx;
      int errs;
      logic [N-1:0] held_idx;
      logic held_f;
      out_ready = 0;
      start = 1;
      step();
      start = 0;
      k = 0; exp_idx = 0; errs = 0;
      while (exp_idx < 16 && k < 200) begin
         out_ready = (k % 3 == 0);
         tt_load = (k == 10); tt_in = 16'hFFFF;
         if (!out_valid || out_idx !== 4'(exp_idx)
             || out_f !== ref_tt[exp_idx]) begin
            errs++;
            $display("FAIL stall_vec k=%0d got idx=%0d f=%b want idx=%0d f=%b",
                     k, out_idx, out_f, exp_idx, ref_tt[exp_idx]);
         end
         held_idx = out_idx; held_f = out_f;
         step();
         if (out_ready) exp_idx++;
         else if (out_idx !== held_idx || out_f !== held_f || !out_valid) begin
            errs++;
            $display("FAIL stall_hold k=%0d got idx=%0d want=%0d",
                     k, out_idx, held_idx);
         end
         k++;
      end
      out_ready = 0; tt_load = 0;
      n_checks++;
      if (exp_idx != 16 || errs != 0)
         $display("FAIL stall_stream got=%0d vecs %0d bad want=16 0",
                  exp_idx, errs);
      else n_pass++;
      n_checks++;
      if ({done, ones_count} !== {1'b1, 5'd7})
         $display("FAIL stall_ones got=%b %0d want=1 7", done, ones_count);
      else n_pass++;
      step();
   endtask

   task automatic test_all_ones();
      ref_tt = 16'hFFFF;
      tt_load = 1; tt_in = ref_tt;
      step();
      tt_load = 0;
      out_ready = 1; start = 1;
      step();
      start = 0;
      for (int i = 0; i < 16; i++) step();
      n_checks++;
      if ({done, ones_count} !== {1'b1, 5'b10000})
         $display("FAIL all_ones got=%b %0d want=1 16", done, ones_count);
      else n_pass++;
      step();
   endtask

   task automatic test_reset_mid();
      int errs;
      out_ready = 1; start = 1;
      step();
      start = 0;
      for (int i = 0; i < 6; i++) step();
      n_checks++;
      if ({out_idx, busy} !== {4'd6, 1'b1})
         $display("FAIL mid_idx got=%0d busy=%b want=6 1", out_idx, busy);
      else n_pass++;
      rst = 1;
      step();
      rst = 0;
      n_checks++;
      if ({out_valid, busy, done, out_f} !== 4'b0000 || ones_count !== 5'd0)
         $display("FAIL mid_rst got=%b ones=%0d want=0000 0",
                  {out_valid, busy, done, out_f}, ones_count);
      else n_pass++;
      step();
      n_checks++;
      if (done !== 1'b0)
         $display("FAIL mid_nodone got=%b want=0", done);
      else n_pass++;
      ref_tt = 16'h0000;
      start = 1;
      step();
      start = 0;
      errs = 0;
      for (int i = 0; i < 16; i++) begin
         if (out_f !== 1'b0 || out_idx !== 4'(i)) errs++;
         step();
      end
      n_checks++;
      if (errs != 0 || done !== 1'b1 || ones_count !== 5'd0)
         $display("FAIL zero_sweep got=%0d bad done=%b ones=%0d want=0 1 0",
                  errs, done, ones_count);
      else n_pass++;
      step();
   endtask

   task automatic test_load_eval_same();
      tt_load = 1; tt_in = 16'hF830;
      step();
      tt_load = 1; tt_in = 16'h0001; eval_en = 1; x = 4'd0;
      step();
      tt_load = 0;
      n_checks++;
      if ({eval_f, eval_valid} !== 2'b01)
         $display("FAIL old_table got=%b%b want=01", eval_f, eval_valid);
      else n_pass++;
      step();
      eval_en = 0;
      n_checks++;
      if ({eval_f, eval_valid} !== 2'b11)
         $display("FAIL new_table got=%b%b want=11", eval_f, eval_valid);
      else n_pass++;
      step();
   endtask

   initial begin
      test_reset();
      test_eval();
      test_sweep_full();
      test_stall();
      test_all_ones();
      test_reset_mid();
      test_load_eval_same();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/lut_sweep_eval.md
Name: lut_sweep_eval

Overview:
- Parametrised, clocked successor to the team's fixed 4-input lab logic functions: holds any N-input Boolean function as a loadable 2^N-entry truth table.
- Two uses: single-vector evaluation with registered output, and an automatic exhaustive sweep over every input combination with a valid/ready output stream.
- Also counts the minterms of the loaded function.
- Sits between lab stimulus logic and a result sink or monitor; replaces per-exercise hand-written benches that step inputs one at a time.

Parameters:
N, 4, number of function inputs (1..6); table depth is 2^N.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
tt_load  input  1  load truth table from tt_in this cycle
tt_in  input  2^N  truth table; bit i = F for input vector i (MSB of vector = first input)
eval_en  input  1  request single evaluation of x
x  input  N  input vector for evaluation
eval_f  output  1  registered F(x)
eval_valid  output  1  one-cycle pulse, eval_f valid
start  input  1  begin sweep (sampled in IDLE only)
out_valid  output  1  sweep output vector valid
out_ready  input  1  sink accepts current sweep output
out_idx  output  N  current sweep input vector
out_f  output  1  F(out_idx)
busy  output  1  high in SWEEP
done  output  1  one-cycle pulse after final vector accepted
ones_count  output  N+1  number of 1 entries seen in completed/ongoing sweep

Behaviour:
- Reset (synchronous, rst=1 at rising edge): table=0, state=IDLE, all outputs 0, ones_count=0. Reset mid-sweep aborts immediately; no done pulse.
- tt_load: honoured only in IDLE; table <= tt_in at clock edge. Ignored in SWEEP and DONE.
- Eval: in IDLE with eval_en=1, next cycle eval_f=table[x] and eval_valid=1 for exactly one cycle.
  - If tt_load and eval_en occur in the same cycle, eval uses the OLD table.
  - eval_en outside IDLE is ignored (eval_valid stays 0).
  - eval_f holds its value between evaluations.
- States: IDLE, SWEEP, DONE.
  - IDLE --start--> SWEEP: out_idx<=0, ones_count<=0, out_valid<=1.
  - If start and eval_en coincide, start wins; eval is dropped.
- SWEEP:
  - out_f = table[out_idx] combinationally from the registered out_idx.
  - Transfer occurs when out_valid&&out_ready. On each transfer, ones_count += out_f.
  - Transfer with out_idx<2^N-1: out_idx increments.
  - Transfer with out_idx=2^N-1: out_valid<=0, state<=DONE; out_idx holds 2^N-1 (no wrap).
  - out_ready low: out_idx, out_f and out_valid held stable; arbitrary stall length allowed.
  - Throughput is 1 vector/cycle with out_ready held high; a full sweep takes 2^N cycles from the first out_valid.
  - start during SWEEP is ignored.
- DONE: done=1 for one cycle, then IDLE.
  - ones_count holds the final value until the next start or rst.
  - ones_count reaches 2^N for an all-ones table; hence N+1 bits.
- busy=1 exactly while state=SWEEP.

Test Plan:
- Reset, load tt_in=16'hF830 (N=4), eval x=4'b1011 then x=4'b0110 -> eval_f=1 then 0, each with a one-cycle eval_valid pulse one cycle after eval_en.
- Same table, start with out_ready=1 -> 16 consecutive out_valid cycles, out_idx 0..15, out_f bit-matches 16'hF830, done pulse on the cycle after idx 15, ones_count=7.
- Sweep with out_ready toggling 1,0,0,1,... -> no index skipped or duplicated, outputs stable while stalled, ones_count=7 at done.
- tt_load=16'hFFFF asserted mid-sweep -> ignored; after the sweep ones_count=7. Then load 16'hFFFF in IDLE and sweep -> ones_count=16 (5'b10000).
- rst pulsed at out_idx=6 -> next cycle out_valid=0, busy=0, no done pulse, table=0. A subsequent sweep gives out_f=0 everywhere and ones_count=0.
- Same cycle tt_load=16'h0001 and eval_en with x=0 (old table 16'hF830) -> eval_f=0. Re-evaluate x=0 -> eval_f=1.
